// File: rtl/frv_core_pkg.sv
// rtl/frv_core_pkg.sv - shared core constants and instruction length decode
package frv_core_pkg;

  localparam int FQ_HW_W = 16;
  localparam int FETCH_W = 32;

  // Low two bits != 2'b11 marks a compressed (16-bit) instruction.
  function automatic logic is_rvc(input logic [FQ_HW_W-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/frv_core_fetch_pc.sv
// rtl/frv_core_fetch_pc.sv - head-of-queue PC register; load on flush, advance on pop
module frv_core_fetch_pc #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic            adv_i,
  input  logic            adv4_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (adv_i) begin
      pc_d = pc_q + (adv4_i ? XLEN'(4) : XLEN'(2));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/frv_core_fetch_queue.sv
// rtl/frv_core_fetch_queue.sv - halfword fetch queue feeding decode with aligned 16/32-bit instructions
module frv_core_fetch_queue
  import frv_core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       g_clk,
  input  logic                       g_reset,
  input  logic                       flush,
  input  logic [XLEN-1:0]            flush_pc,
  input  logic                       f_valid,
  input  logic                       f_2byte,
  input  logic                       f_err,
  input  logic [FETCH_W-1:0]         f_in,
  output logic                       f_ready,
  output logic [$clog2(DEPTH+1)-1:0] buf_depth,
  output logic                       buf_valid,
  output logic                       buf_16,
  output logic                       buf_32,
  output logic [FETCH_W-1:0]         buf_out,
  output logic [XLEN-1:0]            buf_pc,
  output logic                       buf_err,
  input  logic                       buf_ready
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int SW = DEPTH * FQ_HW_W;

  logic [SW-1:0]      data_q, data_d, ins_data;
  logic [DEPTH-1:0]   err_q, err_d, ins_err;
  logic [DW-1:0]      depth_q, depth_d, pop_cnt, push_cnt, ins_idx;
  logic [FQ_HW_W-1:0] hw0, hw1;
  logic               has1, has2, head_32, pop, push;

  assign hw0     = data_q[FQ_HW_W-1:0];
  assign hw1     = data_q[2*FQ_HW_W-1:FQ_HW_W];
  assign has1    = depth_q != '0;
  assign has2    = depth_q >= DW'(2);
  assign head_32 = has1 && !is_rvc(hw0);

  assign buf_16    = has1 && is_rvc(hw0);
  assign buf_32    = head_32;
  // An errored head is presented even without its upper half so faults never stall.
  assign buf_valid = buf_16 || (head_32 && has2) || (has1 && err_q[0]);
  assign buf_err   = err_q[0] | (head_32 & has2 & err_q[1]);
  assign buf_out   = head_32 ? {hw1, hw0} : {{(FETCH_W-FQ_HW_W){1'b0}}, hw0};
  assign buf_depth = depth_q;

  assign pop      = buf_valid && buf_ready;
  assign pop_cnt  = !pop ? '0 : (head_32 && has2) ? DW'(2) : DW'(1);
  assign ins_idx  = depth_q - pop_cnt;
  assign f_ready  = ins_idx <= DW'(DEPTH - 2);
  assign push     = f_valid && f_ready;
  assign push_cnt = !push ? '0 : f_2byte ? DW'(1) : DW'(2);

  // Slots above depth are kept zero so new halfwords can simply be OR-ed in.
  always_comb begin
    ins_data = '0;
    ins_err  = '0;
    if (f_2byte) begin
      ins_data[FQ_HW_W-1:0] = f_in[FETCH_W-1:FQ_HW_W];
      ins_err[0]            = f_err;
    end else begin
      ins_data[FETCH_W-1:0] = f_in;
      ins_err[1:0]          = {2{f_err}};
    end
    data_d  = data_q >> (int'(pop_cnt) * FQ_HW_W);
    err_d   = err_q >> pop_cnt;
    depth_d = depth_q - pop_cnt + push_cnt;
    if (push) begin
      data_d = data_d | (ins_data << (int'(ins_idx) * FQ_HW_W));
      err_d  = err_d | (ins_err << ins_idx);
    end
    if (flush) begin
      data_d  = '0;
      err_d   = '0;
      depth_d = '0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      data_q  <= '0;
      err_q   <= '0;
      depth_q <= '0;
    end else begin
      data_q  <= data_d;
      err_q   <= err_d;
      depth_q <= depth_d;
    end
  end

  frv_core_fetch_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk_i     (g_clk),
    .reset_i   (g_reset),
    .load_i    (flush),
    .load_pc_i (flush_pc),
    .adv_i     (pop),
    .adv4_i    (pop_cnt == DW'(2)),
    .pc_o      (buf_pc)
  );

endmodule

// File: tb/tb_frv_core_fetch_queue.sv
// tb/tb_frv_core_fetch_queue.sv - scoreboard bench for the halfword fetch queue
module tb_frv_core_fetch_queue;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        g_clk = 1'b0;
  logic        g_reset, flush, f_valid, f_2byte, f_err, buf_ready;
  logic [31:0] flush_pc, f_in;
  logic        f_ready, buf_valid, buf_16, buf_32, buf_err;
  logic [3:0]  buf_depth;
  logic [31:0] buf_out, buf_pc;

  frv_core_fetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .f_valid   (f_valid),
    .f_2byte   (f_2byte),
    .f_err     (f_err),
    .f_in      (f_in),
    .f_ready   (f_ready),
    .buf_depth (buf_depth),
    .buf_valid (buf_valid),
    .buf_16    (buf_16),
    .buf_32    (buf_32),
    .buf_out   (buf_out),
    .buf_pc    (buf_pc),
    .buf_err   (buf_err),
    .buf_ready (buf_ready)
  );

  always #5 g_clk = ~g_clk;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
  } hw_t;

  hw_t         hq[$];
  logic [31:0] m_pc;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic fv, input logic f2, input logic fe,
                        input logic [31:0] fin, input logic br);
    f_valid   = fv;
    f_2byte   = f2;
    f_err     = fe;
    f_in      = fin;
    buf_ready = br;
  endtask

  task automatic push_hw(input logic [15:0] d, input logic e);
    hw_t x;
    x.d = d;
    x.e = e;
    hq.push_back(x);
  endtask

  // One clock: check outputs against the model, score pops, then advance the model.
  task automatic cyc();
    logic [15:0] h0, h1;
    logic        e0, e1, is32, vexp, eexp, rexp;
    int          sz, n;
    #2;
    sz = hq.size();
    h0 = '0; h1 = '0; e0 = 1'b0; e1 = 1'b0; is32 = 1'b0; vexp = 1'b0; n = 0;
    if (sz >= 1) begin
      h0   = hq[0].d;
      e0   = hq[0].e;
      is32 = (h0[1:0] == 2'b11);
      vexp = !is32 || sz >= 2 || e0;
    end
    if (sz >= 2) begin
      h1 = hq[1].d;
      e1 = hq[1].e;
    end
    eexp = e0 | (is32 & (sz >= 2) & e1);
    chk("depth", buf_depth, sz);
    chk("pc", buf_pc, m_pc);
    chk("valid", buf_valid, vexp);
    chk("is16", buf_16, sz >= 1 && !is32);
    chk("is32", buf_32, sz >= 1 && is32);
    if (vexp && buf_ready) begin
      n = (is32 && sz >= 2) ? 2 : 1;
      if (!is32)          chk("sb_out16", buf_out, {16'h0, h0});
      else if (sz >= 2)   chk("sb_out32", buf_out, {h1, h0});
      else                chk("sb_out_lo", buf_out[15:0], h0);
      chk("sb_err", buf_err, eexp);
    end
    rexp = (sz - n) <= DEPTH - 2;
    chk("f_ready", f_ready, rexp);
    if (flush) begin
      hq.delete();
      m_pc = flush_pc;
    end else begin
      for (int k = 0; k < n; k++) void'(hq.pop_front());
      m_pc = m_pc + 32'(2 * n);
      if (f_valid && rexp) begin
        if (f_2byte) begin
          push_hw(f_in[31:16], f_err);
        end else begin
          push_hw(f_in[15:0], f_err);
          push_hw(f_in[31:16], f_err);
        end
      end
    end
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_reset(input logic with_flush);
    g_reset  = 1'b1;
    flush    = with_flush;
    flush_pc = 32'hdead_0000;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge g_clk); #1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    flush   = 1'b0;
    hq.delete();
    m_pc = RST_PC;
  endtask

  task automatic drain();
    int g;
    g = 0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    while (hq.size() != 0 && g < 40) begin
      cyc();
      g++;
    end
    chk("drain_depth", buf_depth, 0);
  endtask

  initial begin
    logic [31:0] p, r;
    flush = 1'b0;
    flush_pc = '0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_reset(1'b1);
    chk("rst_depth", buf_depth, 0);
    chk("rst_pc", buf_pc, RST_PC);
    chk("rst_valid", buf_valid, 0);
    chk("rst_16", buf_16, 0);
    chk("rst_32", buf_32, 0);
    chk("rst_out", buf_out, 0);
    chk("rst_err", buf_err, 0);
    chk("rst_ready", f_ready, 1);

    set_in(1'b1, 1'b0, 1'b0, 32'h0001_4501, 1'b0); cyc();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("s1_16", buf_16, 1);
    chk("s1_out", buf_out, 32'h0000_4501);
    chk("s1_pc", buf_pc, RST_PC);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); cyc();
    chk("s1_head2", buf_out, 32'h0000_0001);
    chk("s1_pc2", buf_pc, RST_PC + 32'd2);
    cyc();

    set_in(1'b1, 1'b0, 1'b0, 32'h0000_0513, 1'b1); cyc();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
    chk("s2_32", buf_32, 1);
    chk("s2_out", buf_out, 32'h0000_0513);
    cyc();
    chk("s2_depth", buf_depth, 0);
    chk("s2_pc", buf_pc, RST_PC + 32'd8);

    set_in(1'b1, 1'b0, 1'b0, 32'h0001_4501, 1'b0); cyc();
    set_in(1'b1, 1'b0, 1'b0, 32'h0000_0513, 1'b0); cyc(); cyc(); cyc();
    chk("s3_depth8", buf_depth, 8);
    chk("s3_full_rdy", f_ready, 0);
    cyc();
    chk("s3_ignored", buf_depth, 8);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
    chk("s3_rdy_pop16", f_ready, 0);
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("s3_depth7", buf_depth, 7);
    chk("s3_rdy_d7", f_ready, 0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); cyc();
    set_in(1'b1, 1'b0, 1'b0, 32'h0000_0513, 1'b0); cyc();
    set_in(1'b1, 1'b0, 1'b0, 32'h0000_0513, 1'b1); #1;
    chk("s3_rdy_pop32", f_ready, 1);
    cyc();
    chk("s3_depth_keep", buf_depth, 8);
    drain();

    set_in(1'b1, 1'b1, 1'b0, 32'h0513_beef, 1'b0); cyc();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("s4_depth1", buf_depth, 1);
    chk("s4_novalid", buf_valid, 0);
    set_in(1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0); cyc();
    chk("s4_valid", buf_valid, 1);
    chk("s4_out", buf_out, 32'h0000_0513);
    drain();

    set_in(1'b1, 1'b1, 1'b1, 32'h0003_0000, 1'b0); cyc();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("s5_valid", buf_valid, 1);
    chk("s5_err", buf_err, 1);
    chk("s5_32", buf_32, 1);
    chk("s5_depth1", buf_depth, 1);
    p = m_pc;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); cyc();
    chk("s5_depth0", buf_depth, 0);
    chk("s5_pc", buf_pc, p + 32'd2);

    set_in(1'b1, 1'b0, 1'b0, 32'h0001_4501, 1'b0); cyc();
    set_in(1'b1, 1'b0, 1'b0, 32'h0001_4501, 1'b1);
    flush = 1'b1;
    flush_pc = 32'h8000_0100;
    cyc();
    flush = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("s6_depth", buf_depth, 0);
    chk("s6_pc", buf_pc, 32'h8000_0100);
    set_in(1'b1, 1'b0, 1'b0, 32'h0001_4501, 1'b0); cyc();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); cyc();
    chk("s6_pc2", buf_pc, 32'h8000_0102);
    drain();

    set_in(1'b1, 1'b0, 1'b0, 32'h0000_0513, 1'b0); cyc();
    do_reset(1'b0);
    chk("rst2_depth", buf_depth, 0);
    chk("rst2_pc", buf_pc, RST_PC);
    chk("rst2_valid", buf_valid, 0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[1:0] = 2'b01;
      if ($urandom_range(0, 1) == 1) r[17:16] = 2'b10;
      set_in(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
             r, 1'($urandom_range(0, 1)));
      flush    = ($urandom_range(0, 29) == 0);
      flush_pc = {$urandom_range(0, 32'h7fff_ffff), 1'b0};
      cyc();
      flush = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
